// File: rtl/mmu2_translator.sv
// mmu2_translator
//   Virtual-to-physical address translator with a small fully-associative TLB
//   and a hardware page-table walker (one- or two-level tables).
//
//   Optional feature macro: MMU2_WRITE_PROTECT_EN
//     defined   -> the leaf PTE writable bit (bit1) is kept per TLB entry and a
//                  write request to a non-writable page faults (hit or walk).
//     undefined -> bit1 is ignored; writes never fault for permission.
//
// Ports
//   iCLOCK, inRESET        clock, asynchronous active-low reset
//   iFLUSH                 invalidate every TLB entry (one cycle later)
//   iREQ/iMODE/iPDT/iRW/iADDR
//                          request strobe, mode (0/3 bypass, 1 one-level,
//                          2 two-level), table base, write flag, virtual addr
//   oBUSY                  request is accepted only while this is low
//   oRESP_VALID/PADDR/FAULT one-cycle response strobe, physical addr, fault
//   oWALK_REQ/iWALK_LOCK/oWALK_ADDR/iWALK_VALID/iWALK_DATA
//                          page-table read port
module mmu2_translator #(
  parameter int TLB_DEPTH = 8,
  parameter int PAGE_BITS = 14,
  parameter int IDX2_BITS = 9
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iREQ,
  input  logic [1:0]  iMODE,
  input  logic [31:0] iPDT,
  input  logic        iRW,
  input  logic [31:0] iADDR,
  output logic        oBUSY,
  output logic        oRESP_VALID,
  output logic [31:0] oRESP_PADDR,
  output logic        oRESP_FAULT,
  output logic        oWALK_REQ,
  input  logic        iWALK_LOCK,
  output logic [31:0] oWALK_ADDR,
  input  logic        iWALK_VALID,
  input  logic [31:0] iWALK_DATA
);

  localparam int VPN_BITS  = 32 - PAGE_BITS;
  localparam int IDX1_BITS = 32 - PAGE_BITS - IDX2_BITS;
  localparam int PTR_BITS  = $clog2(TLB_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L2_REQ,
    L2_WAIT,
    RESP
  } state_t;

  state_t                state;
  logic                  busy_q;
  logic                  resp_valid;
  logic                  resp_fault;
  logic [31:0]           resp_paddr;
  logic                  walk_req;
  logic [31:0]           walk_addr;
  logic                  two_level;
  logic [31:0]           addr_q;
  logic                  flush_seen;

  logic [TLB_DEPTH-1:0]  tlb_valid;
  logic [VPN_BITS-1:0]   tlb_vpn   [TLB_DEPTH];
  logic [VPN_BITS-1:0]   tlb_frame [TLB_DEPTH];
  logic [PTR_BITS-1:0]   fill_ptr;

`ifdef MMU2_WRITE_PROTECT_EN
  logic [TLB_DEPTH-1:0]  tlb_wr;
  logic                  rw_q;
  logic                  hit_wr;
`endif

  logic                  accept;
  logic                  bypass;
  logic                  hit;
  logic [VPN_BITS-1:0]   hit_frame;
  logic                  hit_deny;
  logic                  walk_deny;
  logic                  walk_fault;
  logic                  leaf_now;
  logic [31:0]           leaf_paddr;
  logic [31:0]           l1_index;
  logic [31:0]           l1_addr;
  logic [31:0]           l2_index;
  logic [31:0]           l2_addr;
  logic                  unused_inputs;

  // A flush in the same cycle blocks acceptance because it raises oBUSY.
  assign accept = iREQ && (state == IDLE) && !iFLUSH;
  assign bypass = (iMODE == 2'd0) || (iMODE == 2'd3);

  // Table addresses are formed from the page-aligned base plus a word index.
  assign l1_index = (iMODE == 2'd2)
                    ? {{(32 - IDX1_BITS){1'b0}}, iADDR[31:PAGE_BITS+IDX2_BITS]}
                    : {{PAGE_BITS{1'b0}}, iADDR[31:PAGE_BITS]};
  assign l1_addr  = {iPDT[31:PAGE_BITS], {PAGE_BITS{1'b0}}} + (l1_index << 2);
  assign l2_index = {{(32 - IDX2_BITS){1'b0}}, addr_q[PAGE_BITS+IDX2_BITS-1:PAGE_BITS]};
  assign l2_addr  = {iWALK_DATA[31:PAGE_BITS], {PAGE_BITS{1'b0}}} + (l2_index << 2);

  // Fully-associative lookup on the incoming VPN; fills never duplicate a VPN.
  always_comb begin
    hit       = 1'b0;
    hit_frame = '0;
`ifdef MMU2_WRITE_PROTECT_EN
    hit_wr    = 1'b0;
`endif
    for (int i = 0; i < TLB_DEPTH; i++) begin
      if (tlb_valid[i] && (tlb_vpn[i] == iADDR[31:PAGE_BITS])) begin
        hit       = 1'b1;
        hit_frame = tlb_frame[i];
`ifdef MMU2_WRITE_PROTECT_EN
        hit_wr    = tlb_wr[i];
`endif
      end
    end
  end

`ifdef MMU2_WRITE_PROTECT_EN
  assign hit_deny      = iRW & ~hit_wr;
  assign walk_deny     = rw_q & ~iWALK_DATA[1];
  assign unused_inputs = ^{iPDT[PAGE_BITS-1:0], iWALK_DATA[PAGE_BITS-1:2]};
`else
  assign hit_deny      = 1'b0;
  assign walk_deny     = 1'b0;
  assign unused_inputs = ^{iPDT[PAGE_BITS-1:0], iWALK_DATA[PAGE_BITS-1:1], iRW};
`endif

  // The walk ends on an invalid L1 entry, on the L1 entry of a one-level
  // table, or on any L2 entry; the returned PTE is then the leaf.
  always_comb begin
    leaf_now = 1'b0;
    if (iWALK_VALID) begin
      if (state == L1_WAIT) begin
        leaf_now = !two_level || !iWALK_DATA[0];
      end else if (state == L2_WAIT) begin
        leaf_now = 1'b1;
      end
    end
  end

  assign walk_fault = ~iWALK_DATA[0] | walk_deny;
  assign leaf_paddr = walk_fault ? 32'd0
                                 : {iWALK_DATA[31:PAGE_BITS], addr_q[PAGE_BITS-1:0]};

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_paddr <= '0;
      walk_req   <= 1'b0;
      walk_addr  <= '0;
      two_level  <= 1'b0;
      addr_q     <= '0;
      flush_seen <= 1'b0;
      tlb_valid  <= '0;
      fill_ptr   <= '0;
      for (int i = 0; i < TLB_DEPTH; i++) begin
        tlb_vpn[i]   <= '0;
        tlb_frame[i] <= '0;
      end
`ifdef MMU2_WRITE_PROTECT_EN
      tlb_wr     <= '0;
      rw_q       <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= iADDR;
            two_level  <= (iMODE == 2'd2);
            flush_seen <= 1'b0;
`ifdef MMU2_WRITE_PROTECT_EN
            rw_q       <= iRW;
`endif
            if (bypass) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_paddr <= iADDR;
            end else if (hit) begin
              resp_valid <= 1'b1;
              resp_fault <= hit_deny;
              resp_paddr <= hit_deny ? 32'd0 : {hit_frame, iADDR[PAGE_BITS-1:0]};
            end else begin
              state     <= L1_REQ;
              busy_q    <= 1'b1;
              walk_req  <= 1'b1;
              walk_addr <= l1_addr;
            end
          end
        end
        // Request and address are held untouched while the port is locked.
        L1_REQ, L2_REQ: begin
          if (!iWALK_LOCK) begin
            state    <= (state == L1_REQ) ? L1_WAIT : L2_WAIT;
            walk_req <= 1'b0;
          end
        end
        L1_WAIT, L2_WAIT: begin
          if (leaf_now) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= walk_fault;
            resp_paddr <= leaf_paddr;
            if (!walk_fault && !flush_seen) begin
              tlb_valid[fill_ptr] <= 1'b1;
              tlb_vpn[fill_ptr]   <= addr_q[31:PAGE_BITS];
              tlb_frame[fill_ptr] <= iWALK_DATA[31:PAGE_BITS];
`ifdef MMU2_WRITE_PROTECT_EN
              tlb_wr[fill_ptr]    <= iWALK_DATA[1];
`endif
              fill_ptr <= (fill_ptr == PTR_BITS'(TLB_DEPTH - 1)) ? '0 : fill_ptr + 1'b1;
            end
          end else if (iWALK_VALID) begin
            state     <= L2_REQ;
            walk_req  <= 1'b1;
            walk_addr <= l2_addr;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Flush overrides any fill in the same cycle and taints a walk in flight.
      if (iFLUSH) begin
        flush_seen <= 1'b1;
        tlb_valid  <= '0;
        fill_ptr   <= '0;
      end
    end
  end

  assign oBUSY       = inRESET & (busy_q | iFLUSH);
  assign oRESP_VALID = resp_valid;
  assign oRESP_PADDR = resp_paddr;
  assign oRESP_FAULT = resp_fault;
  assign oWALK_REQ   = walk_req;
  assign oWALK_ADDR  = walk_addr;

endmodule

// File: tb/tb_mmu2_translator.sv
// tb_mmu2_translator
//   Directed self-checking bench for mmu2_translator. Expected values are
//   hand-computed for PAGE_BITS=14, IDX2_BITS=9, TLB_DEPTH=8. Define
//   MMU2_WRITE_PROTECT_EN for both files to exercise the write-protect build.
module tb_mmu2_translator;

  localparam int DEPTH = 8;

`ifdef MMU2_WRITE_PROTECT_EN
  localparam logic WP_ON = 1'b1;
`else
  localparam logic WP_ON = 1'b0;
`endif

  logic        iCLOCK;
  logic        inRESET;
  logic        iFLUSH;
  logic        iREQ;
  logic [1:0]  iMODE;
  logic [31:0] iPDT;
  logic        iRW;
  logic [31:0] iADDR;
  logic        oBUSY;
  logic        oRESP_VALID;
  logic [31:0] oRESP_PADDR;
  logic        oRESP_FAULT;
  logic        oWALK_REQ;
  logic        iWALK_LOCK;
  logic [31:0] oWALK_ADDR;
  logic        iWALK_VALID;
  logic [31:0] iWALK_DATA;

  int check_count = 0;
  int fail_count  = 0;

  mmu2_translator #(
    .TLB_DEPTH(DEPTH),
    .PAGE_BITS(14),
    .IDX2_BITS(9)
  ) dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iFLUSH      (iFLUSH),
    .iREQ        (iREQ),
    .iMODE       (iMODE),
    .iPDT        (iPDT),
    .iRW         (iRW),
    .iADDR       (iADDR),
    .oBUSY       (oBUSY),
    .oRESP_VALID (oRESP_VALID),
    .oRESP_PADDR (oRESP_PADDR),
    .oRESP_FAULT (oRESP_FAULT),
    .oWALK_REQ   (oWALK_REQ),
    .iWALK_LOCK  (iWALK_LOCK),
    .oWALK_ADDR  (oWALK_ADDR),
    .iWALK_VALID (iWALK_VALID),
    .iWALK_DATA  (iWALK_DATA)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Waits for oBUSY low, presents one request for one edge, then scrambles
  // the inputs so a design that fails to latch them is exposed.
  task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] pdt,
                               input logic rw, input logic [31:0] addr);
    for (int i = 0; i < 20 && oBUSY; i++) tick();
    checkOutput("accept_ready", 32'(oBUSY), 32'd0);
    iREQ  = 1'b1;
    iMODE = mode;
    iPDT  = pdt;
    iRW   = rw;
    iADDR = addr;
    tick();
    iREQ  = 1'b0;
    iMODE = 2'd2;
    iPDT  = 32'hFFFF_FFFF;
    iRW   = ~rw;
    iADDR = 32'hFFFF_FFFF;
  endtask

  // Serves one table read; while locked, a stray iWALK_VALID is also driven.
  task automatic serveWalk(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] data, input int lock_cycles);
    for (int i = 0; i < 20 && !oWALK_REQ; i++) tick();
    checkOutput({tag, "_req"}, 32'(oWALK_REQ), 32'd1);
    checkOutput({tag, "_addr"}, oWALK_ADDR, exp_addr);
    if (lock_cycles > 0) begin
      iWALK_LOCK  = 1'b1;
      iWALK_VALID = 1'b1;
      iWALK_DATA  = 32'hFFFF_C001;
      for (int i = 0; i < lock_cycles; i++) begin
        tick();
        checkOutput({tag, "_lock_req"}, 32'(oWALK_REQ), 32'd1);
        checkOutput({tag, "_lock_addr"}, oWALK_ADDR, exp_addr);
      end
      iWALK_LOCK  = 1'b0;
      iWALK_VALID = 1'b0;
      iWALK_DATA  = 32'd0;
    end
    tick();
    iWALK_VALID = 1'b1;
    iWALK_DATA  = data;
    tick();
    iWALK_VALID = 1'b0;
    iWALK_DATA  = 32'd0;
  endtask

  task automatic expectResp(input string tag, input logic [31:0] paddr,
                            input logic fault);
    for (int i = 0; i < 20 && !oRESP_VALID; i++) tick();
    checkOutput({tag, "_valid"}, 32'(oRESP_VALID), 32'd1);
    checkOutput({tag, "_paddr"}, oRESP_PADDR, paddr);
    checkOutput({tag, "_fault"}, 32'(oRESP_FAULT), 32'(fault));
  endtask

  initial begin
    inRESET     = 1'b0;
    iFLUSH      = 1'b0;
    iREQ        = 1'b0;
    iMODE       = 2'd0;
    iPDT        = 32'd0;
    iRW         = 1'b0;
    iADDR       = 32'd0;
    iWALK_LOCK  = 1'b0;
    iWALK_VALID = 1'b0;
    iWALK_DATA  = 32'd0;

    // Reset values
    repeat (2) @(posedge iCLOCK);
    #1;
    checkOutput("rst_busy",   32'(oBUSY),       32'd0);
    checkOutput("rst_valid",  32'(oRESP_VALID), 32'd0);
    checkOutput("rst_fault",  32'(oRESP_FAULT), 32'd0);
    checkOutput("rst_paddr",  oRESP_PADDR,      32'd0);
    checkOutput("rst_wreq",   32'(oWALK_REQ),   32'd0);
    checkOutput("rst_waddr",  oWALK_ADDR,       32'd0);
    inRESET = 1'b1;
    tick();

    // Bypass, modes 0 and 3
    applyStimulus(2'd0, 32'h0010_0000, 1'b0, 32'h1234_5678);
    checkOutput("byp_nowalk", 32'(oWALK_REQ), 32'd0);
    expectResp("byp0", 32'h1234_5678, 1'b0);
    applyStimulus(2'd3, 32'h0010_0000, 1'b0, 32'hDEAD_BEEF);
    checkOutput("byp3_nowalk", 32'(oWALK_REQ), 32'd0);
    expectResp("byp3", 32'hDEAD_BEEF, 1'b0);

    // Mode-1 miss then hit on the same VPN (2)
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0000_8010);
    checkOutput("miss_busy", 32'(oBUSY), 32'd1);
    serveWalk("m1", 32'h0010_0008, 32'h0ABC_C001, 0);
    checkOutput("resp_busy", 32'(oBUSY), 32'd1);
    expectResp("m1_miss", 32'h0ABC_C010, 1'b0);
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0000_A123);
    checkOutput("m1_hit_nowalk", 32'(oWALK_REQ), 32'd0);
    checkOutput("m1_hit_1cyc", 32'(oRESP_VALID), 32'd1);
    expectResp("m1_hit", 32'h0ABC_E123, 1'b0);

    // Mode-2: locked L1 read with an invalid PTE, then a full two-level walk
    applyStimulus(2'd2, 32'h0020_0000, 1'b0, 32'h0180_4ABC);
    serveWalk("m2_l1f", 32'h0020_000C, 32'h0000_0000, 3);
    checkOutput("m2_no_l2", 32'(oWALK_REQ), 32'd0);
    expectResp("m2_fault", 32'd0, 1'b1);
    applyStimulus(2'd2, 32'h0020_0000, 1'b0, 32'h0180_4ABC);
    serveWalk("m2_l1", 32'h0020_000C, 32'h0030_4001, 0);
    serveWalk("m2_l2", 32'h0030_4004, 32'h1234_0003, 1);
    expectResp("m2_walk", 32'h1234_0ABC, 1'b0);
    applyStimulus(2'd2, 32'h0020_0000, 1'b0, 32'h0180_4000);
    checkOutput("m2_hit_nowalk", 32'(oWALK_REQ), 32'd0);
    expectResp("m2_hit", 32'h1234_0000, 1'b0);

    // Flush together with a request: not accepted, TLB then empty
    iFLUSH = 1'b1;
    iREQ   = 1'b1;
    iMODE  = 2'd0;
    iADDR  = 32'h1111_1111;
    #1;
    checkOutput("flush_busy", 32'(oBUSY), 32'd1);
    tick();
    iFLUSH = 1'b0;
    iREQ   = 1'b0;
    checkOutput("flush_noacc", 32'(oRESP_VALID), 32'd0);
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0000_8010);
    serveWalk("post_flush", 32'h0010_0008, 32'h0ABC_C001, 0);
    expectResp("post_flush", 32'h0ABC_C010, 1'b0);

    // Round-robin wrap: DEPTH+1 fills evict the first VPN only
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      applyStimulus(2'd1, 32'h0010_0000, 1'b0, (32'h100 + 32'(k)) << 14);
      serveWalk("rr_fill", 32'h0010_0400 + 32'(4 * k), 32'h2000_0001 + (32'(k) << 14), 0);
      expectResp("rr_fill", 32'h2000_0000 + (32'(k) << 14), 1'b0);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(2'd1, 32'h0010_0000, 1'b0, ((32'h100 + 32'(k)) << 14) | 32'h123);
      checkOutput("rr_hit_nowalk", 32'(oWALK_REQ), 32'd0);
      expectResp("rr_hit", 32'h2000_0123 + (32'(k) << 14), 1'b0);
    end
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0040_0000);
    serveWalk("rr_evicted", 32'h0010_0400, 32'h2000_0001, 0);
    expectResp("rr_evicted", 32'h2000_0000, 1'b0);

    // Flush mid-walk: response normal, fill suppressed, old entries gone
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h00C0_0055);
    iFLUSH     = 1'b1;
    iWALK_LOCK = 1'b1;
    tick();
    iFLUSH     = 1'b0;
    iWALK_LOCK = 1'b0;
    serveWalk("fl_walk", 32'h0010_0C00, 32'h3000_0001, 0);
    expectResp("fl_walk", 32'h3000_0055, 1'b0);
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h00C0_0055);
    serveWalk("fl_refetch", 32'h0010_0C00, 32'h3000_0001, 0);
    expectResp("fl_refetch", 32'h3000_0055, 1'b0);
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0041_4123);
    serveWalk("fl_cleared", 32'h0010_0414, 32'h2001_4001, 0);
    expectResp("fl_cleared", 32'h2001_4123, 1'b0);

    // Write protect: read-fill of a read-only page, then writes
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0140_00AA);
    serveWalk("wp_rd", 32'h0010_1400, 32'h4000_0001, 0);
    expectResp("wp_rd", 32'h4000_00AA, 1'b0);
    applyStimulus(2'd1, 32'h0010_0000, 1'b1, 32'h0140_00AA);
    checkOutput("wp_hit_nowalk", 32'(oWALK_REQ), 32'd0);
    expectResp("wp_hit", WP_ON ? 32'd0 : 32'h4000_00AA, WP_ON);
    applyStimulus(2'd1, 32'h0010_0000, 1'b1, 32'h0140_40BB);
    serveWalk("wp_walk", 32'h0010_1404, 32'h5000_0001, 0);
    expectResp("wp_walk", WP_ON ? 32'd0 : 32'h5000_00BB, WP_ON);
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0140_40BB);
    checkOutput("wp_nofill", 32'(oWALK_REQ), 32'(WP_ON));

    // Reset pulse clears any pending activity
    tick();
    inRESET = 1'b0;
    #1;
    checkOutput("rst2_busy",  32'(oBUSY),       32'd0);
    checkOutput("rst2_wreq",  32'(oWALK_REQ),   32'd0);
    checkOutput("rst2_waddr", oWALK_ADDR,       32'd0);
    checkOutput("rst2_valid", 32'(oRESP_VALID), 32'd0);
    inRESET = 1'b1;
    tick();

    // Reset mid-walk: no response, no fill
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0001_C000);
    tick();
    iWALK_VALID = 1'b1;
    iWALK_DATA  = 32'h6000_0001;
    inRESET     = 1'b0;
    #1;
    checkOutput("rstw_wreq",  32'(oWALK_REQ),   32'd0);
    checkOutput("rstw_valid", 32'(oRESP_VALID), 32'd0);
    inRESET = 1'b1;
    tick();
    iWALK_VALID = 1'b0;
    iWALK_DATA  = 32'd0;
    tick();
    checkOutput("rstw_noresp", 32'(oRESP_VALID), 32'd0);
    applyStimulus(2'd1, 32'h0010_0000, 1'b0, 32'h0001_C000);
    serveWalk("rstw_refetch", 32'h0010_001C, 32'h6000_0001, 0);
    expectResp("rstw_refetch", 32'h6000_0000, 1'b0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mmu2_translator.md
MMU2_TRANSLATOR -- requirements
Module: mmu2_translator

Interface
REQ-001 SHALL have parameter TLB_DEPTH, default 8, meaning number of fully-associative TLB entries (power of 2, at least 2).
REQ-002 SHALL have parameter PAGE_BITS, default 14, meaning page offset width (16KB pages).
REQ-003 SHALL have parameter IDX2_BITS, default 9, meaning level-2 index width for two-level walks.
REQ-004 SHALL have port iCLOCK, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port inRESET, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port iFLUSH, input, 1, meaning invalidate all TLB entries.
REQ-007 SHALL have ports iREQ in 1, iMODE in 2, iPDT in 32, iRW in 1, iADDR in 32, meaning request, mode (0=bypass, 1=one-level, 2=two-level, 3=reserved and treated as bypass), table base, write flag, and virtual address.
REQ-008 SHALL have port oBUSY, output, 1; a request is accepted only when iREQ=1 and oBUSY=0.
REQ-009 SHALL have ports oRESP_VALID out 1, oRESP_PADDR out 32, oRESP_FAULT out 1, meaning the one-cycle response strobe, the physical address, and the page fault flag.
REQ-010 SHALL have ports oWALK_REQ out 1, iWALK_LOCK in 1, oWALK_ADDR out 32, iWALK_VALID in 1, iWALK_DATA in 32, forming the page-table read port.

Function
REQ-011 SHALL use PTE format: bit0=valid, bit1=writable, [31:PAGE_BITS]=frame.
REQ-012 SHALL respond in bypass mode one cycle after accept, with PADDR=ADDR and FAULT=0, with no TLB access.
REQ-013 SHALL look up VPN=ADDR[31:PAGE_BITS] on accept; on a hit it SHALL respond one cycle later with PADDR={frame, ADDR[PAGE_BITS-1:0]}.
REQ-014 SHALL, on a miss, start a walk with FSM states IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP.
REQ-015 SHALL hold the walk in IDLE->L1_REQ on miss, and move L1_REQ->L1_WAIT and L2_REQ->L2_WAIT when oWALK_REQ=1 and iWALK_LOCK=0.
REQ-016 SHALL hold oWALK_REQ and oWALK_ADDR stable while iWALK_LOCK=1.
REQ-017 SHALL compute the L1 address as {iPDT[31:PAGE_BITS],0} + (VPN<<2) in mode 1, and {iPDT[31:PAGE_BITS],0} + (ADDR[31:PAGE_BITS+IDX2_BITS]<<2) in mode 2; all sums are modulo 2^32.
REQ-018 SHALL compute the L2 address as {L1 frame,0} + (ADDR[PAGE_BITS+IDX2_BITS-1:PAGE_BITS]<<2).
REQ-019 SHALL, in L1_WAIT on iWALK_VALID, go to RESP in mode 1 or when PTE bit0=0, and otherwise to L2_REQ; in L2_WAIT on iWALK_VALID it SHALL go to RESP.
REQ-020 SHALL have RESP assert oRESP_VALID for one cycle and then return to IDLE; FAULT=1 if any fetched PTE has bit0=0, and PADDR is then 0.
REQ-021 SHALL fill the TLB only on a non-faulting walk, at a round-robin pointer that wraps from TLB_DEPTH-1 to 0; the pointer advances only on a fill.
REQ-022 SHALL keep oBUSY=1 from the miss cycle through RESP inclusive, and whenever iFLUSH=1.
REQ-023 SHALL clear all valid bits one cycle after iFLUSH=1 and reset the pointer to 0.
REQ-024 SHALL, on a flush during a walk, complete the walk and respond but suppress the fill.
REQ-025 SHALL latch the mode, PDT, address and RW on accept; input changes during a walk SHALL be ignored.
REQ-026 SHALL ignore iWALK_VALID outside the L1_WAIT and L2_WAIT states.

Reset
REQ-027 SHALL, during reset, hold the FSM in IDLE, clear all TLB valid bits, set the pointer to 0, and drive oBUSY, oRESP_VALID, oRESP_FAULT and oWALK_REQ to 0 and oRESP_PADDR and oWALK_ADDR to 0.
REQ-028 SHALL, on reset mid-walk, abandon the walk with no response and no fill.

Configuration
REQ-029 SHALL, with MMU2_WRITE_PROTECT_EN defined, store the leaf writable bit per TLB entry and fault any iRW=1 request whose leaf bit1=0, on both hit and walk paths; a faulting walk SHALL not fill.
REQ-030 SHALL, without MMU2_WRITE_PROTECT_EN, ignore bit1 and not store it; writes never fault for permission.

Verification
REQ-031 SHALL cover bypass: MODE=0, ADDR=0x12345678 -> next cycle VALID=1, PADDR=0x12345678, FAULT=0, no oWALK_REQ.
REQ-032 SHALL cover a mode-1 miss then hit: PDT=0x00100000, ADDR=0x00008010 -> oWALK_ADDR=0x00100008; data 0x0ABCC001 -> PADDR=0x0ABCC010; the same VPN again -> response in 1 cycle, no walk.
REQ-033 SHALL cover a mode-2 walk with iWALK_LOCK held 3 cycles: the address stays stable; an L1 PTE with bit0=0 -> FAULT=1, no L2 read, no fill.
REQ-034 SHALL cover round-robin wrap: fill TLB_DEPTH+1 distinct VPNs -> the first VPN misses again and all others hit.
REQ-035 SHALL cover flush mid-walk: the walk responds normally, then the same VPN misses; iFLUSH with iREQ in the same cycle -> not accepted.
REQ-036 SHALL cover write protect with the macro defined: iRW=1 to a PTE with bit1=0 -> FAULT=1; the same case with the macro undefined -> FAULT=0.
